fetch_stage: RTL and testbench

// Instruction-fetch stage directly upstream of the instruction memory. Holds the PC, drives the
// 8-bit word address to the memory, captures the returned 32-bit word into the IF/ID register
// and presents it to decode. Handles stall, flush, branch/jump redirect and a HALT stop state.

---
 rtl/fetch_stage.sv | 124 ++++++++++++
 tb/tb_fetch_stage.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC, instruction-memory addressing, IF/ID register, HALT stop state.
// Optional FETCH_PERF_EN adds perf_fetched / perf_stalls counters.
module fetch_stage #(
    parameter int                 ADDR_W    = 8,
    parameter int                 DATA_W    = 32,
    parameter logic [ADDR_W-1:0]  RESET_PC  = '0,
    parameter logic [DATA_W-1:0]  NOP_WORD  = 32'h0000_0000,
    parameter logic [DATA_W-1:0]  HALT_WORD = 32'hFFFF_FFFF
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [DATA_W-1:0] imem_rd,
    input  logic              stall,
    input  logic              flush,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_addr,
    output logic [DATA_W-1:0] if_id_instr,
    output logic [ADDR_W-1:0] if_id_pc,
    output logic [ADDR_W-1:0] if_id_pc_next,
    output logic              if_id_valid,
    output logic              halted
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]       perf_fetched,
    output logic [31:0]       perf_stalls
`endif
);

    typedef enum logic {S_RUN, S_HALTED} state_t;

    state_t            r_state;
    logic [ADDR_W-1:0] r_pc;
    logic [DATA_W-1:0] r_instr;
    logic [ADDR_W-1:0] r_if_pc;
    logic [ADDR_W-1:0] r_if_pc_next;
    logic              r_valid;
    logic              r_halted;

    logic [ADDR_W-1:0] w_pc_inc;
    logic              w_is_halt;
    logic              w_capture;

    assign w_pc_inc  = r_pc + {{(ADDR_W-1){1'b0}}, 1'b1};
    assign w_is_halt = (imem_rd == HALT_WORD);
    // The only edge that loads a real instruction into IF/ID.
    assign w_capture = (r_state == S_RUN) && !redirect_valid && !flush && !stall;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= S_RUN;
            r_pc         <= RESET_PC;
            r_instr      <= NOP_WORD;
            r_if_pc      <= '0;
            r_if_pc_next <= '0;
            r_valid      <= 1'b0;
            r_halted     <= 1'b0;
        end else begin
            case (r_state)
                S_RUN: begin
                    if (redirect_valid) begin
                        r_pc    <= redirect_addr;
                        r_instr <= NOP_WORD;
                        r_valid <= 1'b0;
                    end else if (flush) begin
                        r_instr <= NOP_WORD;
                        r_valid <= 1'b0;
                        if (!stall) r_pc <= w_pc_inc;
                    end else if (!stall) begin
                        r_instr      <= imem_rd;
                        r_if_pc      <= r_pc;
                        r_if_pc_next <= w_pc_inc;
                        r_valid      <= 1'b1;
                        // HALT freezes the PC on the halt word's own address.
                        if (w_is_halt) begin
                            r_state  <= S_HALTED;
                            r_halted <= 1'b1;
                        end else begin
                            r_pc <= w_pc_inc;
                        end
                    end
                end
                S_HALTED: begin
                    if (redirect_valid) begin
                        r_pc     <= redirect_addr;
                        r_instr  <= NOP_WORD;
                        r_valid  <= 1'b0;
                        r_state  <= S_RUN;
                        r_halted <= 1'b0;
                    end else if (!stall) begin
                        r_instr <= NOP_WORD;
                        r_valid <= 1'b0;
                    end
                end
            endcase
        end
    end

`ifdef FETCH_PERF_EN
    logic [31:0] r_perf_fetched;
    logic [31:0] r_perf_stalls;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_perf_fetched <= '0;
            r_perf_stalls  <= '0;
        end else begin
            if (w_capture)                r_perf_fetched <= r_perf_fetched + 32'd1;
            if (stall && !redirect_valid) r_perf_stalls  <= r_perf_stalls + 32'd1;
        end
    end

    assign perf_fetched = r_perf_fetched;
    assign perf_stalls  = r_perf_stalls;
`endif

    assign imem_addr     = r_pc;
    assign if_id_instr   = r_instr;
    assign if_id_pc      = r_if_pc;
    assign if_id_pc_next = r_if_pc_next;
    assign if_id_valid   = r_valid;
    assign halted        = r_halted;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios plus randomized traffic, all checked against an
// abstract fetch model (PC, IF/ID contents, halt flag) built from the stage's rules.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  imem_addr;
    logic [31:0] imem_rd;
    logic        stall, flush, redirect_valid;
    logic [7:0]  redirect_addr;
    logic [31:0] if_id_instr;
    logic [7:0]  if_id_pc, if_id_pc_next;
    logic        if_id_valid, halted;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched, perf_stalls;
`endif

    logic [31:0] mem [256];
    assign imem_rd = mem[imem_addr];

    always #5 clk = ~clk;

    fetch_stage dut (
        .clk(clk), .rst_n(rst_n), .imem_addr(imem_addr), .imem_rd(imem_rd),
        .stall(stall), .flush(flush), .redirect_valid(redirect_valid),
        .redirect_addr(redirect_addr), .if_id_instr(if_id_instr), .if_id_pc(if_id_pc),
        .if_id_pc_next(if_id_pc_next), .if_id_valid(if_id_valid), .halted(halted)
`ifdef FETCH_PERF_EN
        , .perf_fetched(perf_fetched), .perf_stalls(perf_stalls)
`endif
    );

    int vectors = 0;
    int miscompares = 0;

    // Abstract model state
    int unsigned m_pc, m_ipc, m_ipcn;
    logic [31:0] m_instr;
    bit          m_valid, m_halt;
    int unsigned m_fetched, m_stalls;

    logic [31:0] prog [5];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic bubble();
        m_instr = 32'h0;
        m_valid = 0;
    endtask

    // One clock edge of the model, using the inputs currently applied.
    task automatic model_edge();
        logic [31:0] w;
        if (!rst_n) begin
            m_pc = 0; m_ipc = 0; m_ipcn = 0; m_instr = 32'h0; m_valid = 0; m_halt = 0;
            m_fetched = 0; m_stalls = 0;
            return;
        end
        if (stall && !redirect_valid) m_stalls++;
        if (redirect_valid) begin
            m_pc = redirect_addr;
            bubble();
            m_halt = 0;
        end else if (m_halt) begin
            if (!stall) bubble();
        end else if (flush) begin
            bubble();
            if (!stall) m_pc = (m_pc + 1) % 256;
        end else if (!stall) begin
            w = mem[m_pc];
            m_instr = w;
            m_ipc   = m_pc;
            m_ipcn  = (m_pc + 1) % 256;
            m_valid = 1;
            m_fetched++;
            if (w == 32'hFFFF_FFFF) m_halt = 1;
            else m_pc = (m_pc + 1) % 256;
        end
    endtask

    task automatic check_all();
        chk("imem_addr", {24'h0, imem_addr}, m_pc);
        chk("if_id_instr", if_id_instr, m_instr);
        chk("if_id_pc", {24'h0, if_id_pc}, m_ipc);
        chk("if_id_pc_next", {24'h0, if_id_pc_next}, m_ipcn);
        chk("if_id_valid", {31'h0, if_id_valid}, {31'h0, m_valid});
        chk("halted", {31'h0, halted}, {31'h0, m_halt});
`ifdef FETCH_PERF_EN
        chk("perf_fetched", perf_fetched, m_fetched);
        chk("perf_stalls", perf_stalls, m_stalls);
`endif
    endtask

    // Inputs are applied at the falling edge; outputs are sampled at the next falling edge.
    task automatic tick();
        model_edge();
        @(posedge clk);
        @(negedge clk);
        check_all();
    endtask

    task automatic set_in(input bit r, input bit s, input bit f, input bit rv, input int ra);
        rst_n = r; stall = s; flush = f; redirect_valid = rv; redirect_addr = 8'(ra);
    endtask

    task automatic do_reset();
        set_in(0, 0, 0, 0, 0);
        tick();
        set_in(1, 0, 0, 0, 0);
    endtask

    initial begin
        prog[0] = 32'h20010003; prog[1] = 32'h20020009; prog[2] = 32'h00221020;
        prog[3] = 32'h00221824; prog[4] = 32'h00222025;
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        for (int i = 0; i < 5; i++) mem[i] = prog[i];
        set_in(0, 0, 0, 0, 0);
        @(negedge clk);

        // Reset state and in-order fetch
        do_reset();
        chk("rst_valid", {31'h0, if_id_valid}, 32'h0);
        chk("rst_addr", {24'h0, imem_addr}, 32'h0);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t1_instr", if_id_instr, prog[i]);
            chk("t1_pc", {24'h0, if_id_pc}, i);
            chk("t1_pcn", {24'h0, if_id_pc_next}, i + 1);
        end
`ifdef FETCH_PERF_EN
        chk("t1_perf_fetched", perf_fetched, 32'd5);
`endif

        // Stall holds PC and IF/ID
        do_reset();
        tick(); tick();
        set_in(1, 1, 0, 0, 0);
        tick(); tick();
        chk("t2_addr", {24'h0, imem_addr}, 32'd2);
        chk("t2_instr", if_id_instr, 32'h20020009);
`ifdef FETCH_PERF_EN
        chk("t2_perf_stalls", perf_stalls, 32'd2);
`endif
        set_in(1, 0, 0, 0, 0);
        tick();
        chk("t2_resume", if_id_instr, 32'h00221020);
        chk("t2_resume_pc", {24'h0, if_id_pc}, 32'd2);

        // Redirect, alone and combined with stall+flush
        for (int k = 0; k < 2; k++) begin
            do_reset();
            for (int i = 0; i < 4; i++) tick();
            set_in(1, k[0], k[0], 1, 0);
            tick();
            chk("t3_bubble_valid", {31'h0, if_id_valid}, 32'h0);
            chk("t3_bubble_instr", if_id_instr, 32'h0);
            set_in(1, 0, 0, 0, 0);
            tick();
            chk("t3_instr", if_id_instr, 32'h20010003);
            chk("t3_pc", {24'h0, if_id_pc}, 32'h0);
        end

        // PC wrap at 255
        mem[255] = 32'h00221020;
        set_in(1, 0, 0, 1, 255);
        tick();
        set_in(1, 0, 0, 0, 0);
        tick();
        chk("t4_pc", {24'h0, if_id_pc}, 32'd255);
        chk("t4_pcn", {24'h0, if_id_pc_next}, 32'd0);
        chk("t4_addr", {24'h0, imem_addr}, 32'd0);

        // HALT and restart
        mem[5] = 32'hFFFF_FFFF;
        do_reset();
        for (int i = 0; i < 6; i++) tick();
        chk("t5_halt_instr", if_id_instr, 32'hFFFF_FFFF);
        chk("t5_halted", {31'h0, halted}, 32'h1);
        chk("t5_addr", {24'h0, imem_addr}, 32'd5);
        set_in(1, 0, 1, 0, 0);  // flush alone must not leave HALTED
        tick();
        set_in(1, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) tick();
        chk("t5_idle_valid", {31'h0, if_id_valid}, 32'h0);
        chk("t5_still_halted", {31'h0, halted}, 32'h1);
        set_in(1, 0, 0, 1, 0);
        tick();
        chk("t5_unhalt", {31'h0, halted}, 32'h0);
        set_in(1, 0, 0, 0, 0);
        tick();
        chk("t5_restart", if_id_instr, 32'h20010003);

        // Reset mid-run overrides stall and redirect
        tick(); tick();
        set_in(0, 1, 0, 1, 7);
        tick();
        chk("t6_valid", {31'h0, if_id_valid}, 32'h0);
        chk("t6_addr", {24'h0, imem_addr}, 32'h0);
        chk("t6_instr", if_id_instr, 32'h0);

        // Randomized traffic against the model
        for (int i = 0; i < 256; i++)
            mem[i] = ($urandom_range(0, 11) == 0) ? 32'hFFFF_FFFF : $urandom;
        do_reset();
        for (int n = 0; n < 2000; n++) begin
            int ra;
            case ($urandom_range(0, 2))
                0:       ra = $urandom_range(250, 255);
                1:       ra = $urandom_range(0, 8);
                default: ra = $urandom_range(0, 255);
            endcase
            set_in($urandom_range(0, 99) != 0, $urandom_range(0, 3) == 0,
                   $urandom_range(0, 5) == 0, $urandom_range(0, 7) == 0, ra);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
